// File: rtl/uart_pkg.sv
// Shared UART constants and the divisor record exchanged with the APB register bank.
package uart_pkg;

  localparam int UART_BAUD_W   = 13;
  localparam int UART_FRAC_W   = 3;
  localparam int UART_OVS_LOG2 = 4;

  typedef struct packed {
    logic [UART_BAUD_W-1:0] baud_val;
    logic [UART_FRAC_W-1:0] baud_frac;
  } uart_div_t;

endpackage

// File: rtl/uart_baud_frac_acc.sv
// Fractional phase accumulator for the baud generator; the carry stretches the next period by one cycle.
module uart_baud_frac_acc
  import uart_pkg::*;
#(
  parameter int FRAC_W = UART_FRAC_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clr,
  input  logic              i_reload,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_carry
);

  logic [FRAC_W-1:0] r_acc;
  logic [FRAC_W:0]   w_sum;

  assign w_sum   = {1'b0, r_acc} + {1'b0, i_frac};
  assign o_carry = w_sum[FRAC_W];

  // accumulator advances only on a reload; clear realigns the fractional phase
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc <= {FRAC_W{1'b0}};
    end else if (i_clr) begin
      r_acc <= {FRAC_W{1'b0}};
    end else if (i_reload) begin
      r_acc <= w_sum[FRAC_W-1:0];
    end else begin
      r_acc <= r_acc;
    end
  end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud-rate generator: oversample tick, bit-rate pulse and phase count.
// Optional fractional path selected by the macro UART_BAUD_FRAC_EN.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int BAUD_W   = UART_BAUD_W,
  parameter int FRAC_W   = UART_FRAC_W,
  parameter int OVS_LOG2 = UART_OVS_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                restart,
  input  logic [BAUD_W-1:0]   baud_val,
  input  logic [FRAC_W-1:0]   baud_frac,
  output logic                baud_tick,
  output logic                xmit_pulse,
  output logic [OVS_LOG2-1:0] phase
);

`ifdef UART_BAUD_FRAC_EN
  // one extra bit so baud_val all-ones plus carry does not wrap to zero
  localparam int CNT_W = BAUD_W + 1;
`else
  localparam int CNT_W = BAUD_W;
`endif

  logic [CNT_W-1:0]    r_cnt;
  logic [OVS_LOG2-1:0] r_phase;
  logic                r_tick;
  logic                r_xmit;
  logic                w_reload;
  logic [CNT_W-1:0]    w_load;

  assign w_reload = en & (r_cnt == {CNT_W{1'b0}});

`ifdef UART_BAUD_FRAC_EN
  logic w_carry;

  uart_baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_acc (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_clr    (restart),
    .i_reload (w_reload),
    .i_frac   (baud_frac),
    .o_carry  (w_carry)
  );

  assign w_load = {1'b0, baud_val} + {{BAUD_W{1'b0}}, w_carry};
`else
  logic w_unused_frac;

  assign w_unused_frac = ^baud_frac;
  assign w_load        = baud_val;
`endif

  // counter, phase and output registers with reset > restart > en priority
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_phase <= {OVS_LOG2{1'b0}};
      r_tick  <= 1'b0;
      r_xmit  <= 1'b0;
    end else if (restart) begin
      r_cnt   <= CNT_W'(baud_val);
      r_phase <= {OVS_LOG2{1'b0}};
      r_tick  <= 1'b0;
      r_xmit  <= 1'b0;
    end else if (w_reload) begin
      r_cnt   <= w_load;
      r_phase <= r_phase + OVS_LOG2'(1);
      r_tick  <= 1'b1;
      r_xmit  <= &r_phase;
    end else if (en) begin
      r_cnt   <= r_cnt - CNT_W'(1);
      r_phase <= r_phase;
      r_tick  <= 1'b0;
      r_xmit  <= 1'b0;
    end else begin
      r_cnt   <= r_cnt;
      r_phase <= r_phase;
      r_tick  <= 1'b0;
      r_xmit  <= 1'b0;
    end
  end

  assign baud_tick  = r_tick;
  assign xmit_pulse = r_xmit;
  assign phase      = r_phase;

endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Parametrised baud-rate generator for the UART core, successor to the fixed 13-bit, 16x, eighth-step clock generator. It produces a single-cycle oversample tick (`baud_tick`) and a bit-rate pulse (`xmit_pulse`) for the transmitter and receiver. Counter width, fraction resolution and oversample ratio are parameters. It adds a general fractional accumulator, a clock enable and a synchronous phase restart. It sits between the APB register bank, which supplies the divisor, and the Tx/Rx state machines.

## Interface
- `BAUD_W`, 13: integer divisor width, 2..16.
- `FRAC_W`, 3: fractional divisor width, 1..8. Resolution is 1/2^FRAC_W cycle.
- `OVS_LOG2`, 4: log2 of the oversample ratio, 1..5. Default gives 16x.
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `en` input 1: count enable.
- `restart` input 1: synchronous phase realign, one-cycle pulse.
- `baud_val` input BAUD_W: integer divisor. Period is baud_val+1 cycles.
- `baud_frac` input FRAC_W: fractional divisor numerator.
- `baud_tick` output 1: oversample tick, one cycle wide.
- `xmit_pulse` output 1: bit-rate pulse, coincident with every 2^OVS_LOG2-th tick.
- `phase` output OVS_LOG2: tick count within the current bit.

## Operation
- Internal state:
  - down-counter `cnt`, BAUD_W+1 bits;
  - accumulator `acc`, FRAC_W bits;
  - phase counter `phase`, OVS_LOG2 bits.
- Priority per edge: `reset` > `restart` > `en`.
- `reset`: cnt=0, acc=0, phase=0, baud_tick=0, xmit_pulse=0.
- `restart`:
  - cnt=baud_val, acc=0, phase=0, baud_tick=0, xmit_pulse=0;
  - applies regardless of `en`.
- `en`=0: cnt, acc and phase hold; baud_tick=0, xmit_pulse=0.
- `en`=1, cnt≠0: cnt decrements; baud_tick=0.
- `en`=1, cnt=0 (reload):
  - baud_tick=1 next cycle;
  - {carry, acc} = acc + baud_frac;
  - cnt loads baud_val + carry, computed in BAUD_W+1 bits so all-ones+1 does not wrap;
  - phase increments modulo 2^OVS_LOG2;
  - xmit_pulse=1 iff phase was all-ones before the increment.
- Resulting period and rate:
  - tick period is baud_val+1, or baud_val+2 on carry;
  - mean period is baud_val+1+baud_frac/2^FRAC_W.
- `baud_val` and `baud_frac` are sampled only at reload or restart. A change mid-period takes effect from the next reload.
- baud_val=0 with baud_frac=0 gives a tick every cycle.
- xmit_pulse is never asserted without baud_tick.

## Timing
- Outputs are registered; nothing is combinational from inputs to outputs.
- First tick:
  - reset released with en=1: cnt=0 on the first free cycle, so baud_tick is high in the following cycle;
  - after restart with en=1: first tick baud_val+1 cycles later.
- Each tick lasts exactly one cycle.
- Reset or restart during a tick or a reload cancels it. No pulse appears in the next cycle.
- An en drop on a cnt=0 cycle defers the reload until en returns. No tick is lost, only delayed.

## Configuration
- `UART_BAUD_FRAC_EN` defined:
  - accumulator and carry path compiled in;
  - behaviour as above.
- Undefined:
  - `baud_frac` port kept but ignored; acc removed;
  - carry is constant 0, so the period is always baud_val+1;
  - cnt width drops to BAUD_W.

## Structure
- Shared package `uart_pkg`:
  - default constants UART_BAUD_W=13, UART_FRAC_W=3, UART_OVS_LOG2=4;
  - typedef for the divisor struct {baud_val, baud_frac}, shared with the register bank.
- Sub-module `uart_baud_frac_acc`:
  - holds acc, takes reload and clear strobes, returns the carry;
  - instantiated only under `UART_BAUD_FRAC_EN`.
- Top level holds cnt, phase and the output registers.

## Test plan
- Integer divide: baud_val=3, baud_frac=0, en=1 → baud_tick every 4 cycles; xmit_pulse on the 16th tick, every 64 cycles; phase cycles 0..15.
- Fractional divide: baud_val=3, FRAC_W=3, baud_frac=4 → periods alternate 4,5; 8 ticks span exactly 36 cycles. With macro undefined, same stimulus gives 32 cycles.
- Boundary: BAUD_W=4, baud_val=15, baud_frac=7 → periods of 17 cycles appear, with no wrap to a 1-cycle period; baud_val=0, baud_frac=0 → tick every cycle.
- Divisor change mid-period: baud_val switched 9→2 five cycles after a tick → that period still ends at 10 cycles; then periods of 3.
- Restart at phase=7, mid-count, baud_val=5 → no tick for 6 cycles; phase=0; next xmit_pulse 16 ticks later.
- Enable/reset: en low for 20 cycles at cnt=0 → no ticks, state held, tick resumes 1 cycle after en rises; reset during xmit cycle → all outputs 0 next cycle, phase=0.
